// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequences the instruction ROM, buffers {word, pc} in a small FIFO
// and hands entries to decode over valid/ready, flushing on branch/jump redirects.
module imem_fetch_ctrl #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             misalign_err,
    output logic             busy,
    output logic [WIDTH-1:0] fetch_count
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] fetch_pc;
    logic [AW:0]      count;
    logic [AW-1:0]    head, tail;
    logic [WIDTH-1:0] q_instr [QUEUE_DEPTH];
    logic [WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic             deq, enq;

    assign rom_addr    = fetch_pc;
    assign instr_valid = count != '0;
    assign instr_out   = instr_valid ? q_instr[head] : '0;
    assign instr_pc    = instr_valid ? q_pc[head] : '0;
    assign busy        = state != IDLE;
    assign deq         = instr_valid & instr_ready;
    assign enq         = (state == RUN) & ~redirect_valid & ((count < FULL) | deq);

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[tail] <= rom_data;
            q_pc[tail]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            count        <= '0;
            head         <= '0;
            tail         <= '0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else if (redirect_valid) begin
            count        <= '0;
            head         <= '0;
            tail         <= '0;
            fetch_pc     <= {redirect_pc[WIDTH-1:2], 2'b00};
            misalign_err <= redirect_pc[1:0] != 2'b00;
            if (state == DRAIN) state <= IDLE;
        end else begin
            misalign_err <= 1'b0;
            count        <= count + (AW+1)'(enq) - (AW+1)'(deq);
            if (deq) head <= head + 1'b1;
            if (enq) begin
                tail        <= tail + 1'b1;
                fetch_pc    <= fetch_pc + WIDTH'(4);
                fetch_count <= fetch_count + WIDTH'(1);
            end
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN:   if (enable) state <= RUN;
                         else if (count == '0 || (count == (AW+1)'(1) && deq)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed checks of startup, streaming, backpressure, redirect, drain and reset.
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, enable, instr_ready, redirect_valid;
    logic [31:0] rom_addr, rom_data, instr_out, instr_pc, redirect_pc, fetch_count;
    logic        instr_valid, misalign_err, busy;
    logic [7:0]  mem [256];
    int          total = 0;
    int          bad = 0;

    imem_fetch_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err), .busy(busy), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign rom_data = {mem[rom_addr[7:0]], mem[rom_addr[7:0] + 8'd1],
                       mem[rom_addr[7:0] + 8'd2], mem[rom_addr[7:0] + 8'd3]};

    function automatic logic [31:0] word(input int p);
        word = {mem[p], mem[p+1], mem[p+2], mem[p+3]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        {mem[0], mem[1], mem[2], mem[3]} = 32'h0050_0093;
        {mem[4], mem[5], mem[6], mem[7]} = 32'h00A0_0113;
        rst = 1'b1; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick(2);
        rst = 1'b0;
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_out", instr_out, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_mis", 32'(misalign_err), 32'h0);
        tick(5);
        chk("idle_addr", rom_addr, 32'h0);
        chk("idle_valid", 32'(instr_valid), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_count", fetch_count, 32'h0);

        enable = 1'b1; instr_ready = 1'b1;
        tick(1);
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_valid", 32'(instr_valid), 32'h0);
        tick(1);
        chk("s0_valid", 32'(instr_valid), 32'h1);
        chk("s0_pc", instr_pc, 32'h0);
        chk("s0_out", instr_out, 32'h0050_0093);
        chk("s0_count", fetch_count, 32'h1);
        chk("s0_addr", rom_addr, 32'h4);
        tick(1);
        chk("s1_pc", instr_pc, 32'h4);
        chk("s1_out", instr_out, 32'h00A0_0113);
        chk("s1_count", fetch_count, 32'h2);
        for (int k = 2; k < 6; k++) begin
            tick(1);
            chk("s_pc", instr_pc, 32'(4 * k));
            chk("s_out", instr_out, word(4 * k));
            chk("s_count", fetch_count, 32'(k + 1));
        end

        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_addr", rom_addr, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_count", fetch_count, 32'h0);
        instr_ready = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(6);
        chk("bp_valid", 32'(instr_valid), 32'h1);
        chk("bp_pc", instr_pc, 32'h0);
        chk("bp_addr", rom_addr, 32'h8);
        chk("bp_count", fetch_count, 32'h2);
        instr_ready = 1'b1;
        tick(1);
        chk("bp_pc4", instr_pc, 32'h4);
        tick(1);
        chk("bp_pc8", instr_pc, 32'h8);
        chk("bp_addr16", rom_addr, 32'h10);

        redirect_valid = 1'b1; redirect_pc = 32'h14;
        tick(1);
        redirect_valid = 1'b0;
        chk("rd_valid", 32'(instr_valid), 32'h0);
        chk("rd_out", instr_out, 32'h0);
        chk("rd_mis", 32'(misalign_err), 32'h0);
        chk("rd_addr", rom_addr, 32'h14);
        tick(1);
        chk("rd_pc14", instr_pc, 32'h14);
        chk("rd_out14", instr_out, word(32'h14));
        chk("rd_mis1", 32'(misalign_err), 32'h0);
        tick(1);
        chk("rd_pc18", instr_pc, 32'h18);
        chk("rd_count", fetch_count, 32'h6);

        redirect_valid = 1'b1; redirect_pc = 32'h1E;
        tick(1);
        redirect_valid = 1'b0;
        chk("mis_err", 32'(misalign_err), 32'h1);
        chk("mis_addr", rom_addr, 32'h1C);
        chk("mis_valid", 32'(instr_valid), 32'h0);
        tick(1);
        chk("mis_clr", 32'(misalign_err), 32'h0);
        chk("mis_pc", instr_pc, 32'h1C);

        instr_ready = 1'b0;
        tick(1);
        enable = 1'b0;
        tick(1);
        chk("dr_busy", 32'(busy), 32'h1);
        chk("dr_pc", instr_pc, 32'h1C);
        tick(2);
        chk("dr_hold", 32'(busy), 32'h1);
        chk("dr_addr", rom_addr, 32'h24);
        instr_ready = 1'b1;
        tick(1);
        chk("dr_busy1", 32'(busy), 32'h1);
        chk("dr_pc20", instr_pc, 32'h20);
        tick(1);
        chk("dr_idle", 32'(busy), 32'h0);
        chk("dr_valid", 32'(instr_valid), 32'h0);
        chk("dr_pc0", instr_pc, 32'h0);
        chk("dr_count", fetch_count, 32'h8);
        tick(2);
        chk("dr_addr2", rom_addr, 32'h24);

        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        chk("idle_rd_addr", rom_addr, 32'h40);
        chk("idle_rd_busy", 32'(busy), 32'h0);
        tick(1);
        chk("idle_rd_valid", 32'(instr_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
